// File: rtl/countdown_mmss.sv
// countdown_mmss
// Four-digit BCD mm:ss countdown timer that sets the run time for one
// irrigation valve. A start/stop FSM wraps a cascaded digit chain
// (sec_units 9->0, sec_tens 5->0, min_units 9->0, min_tens 9->0).
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   tick                 1 Hz enable, one clock wide; decrements in RUN
//   start, stop          control levels; stop always wins
//   preset_*             preset digits, clamped to legal BCD on load
//   min_tens..sec_units  current count
//   running, valve_on    high in RUN
//   done                 one-cycle pulse when the count expires
module countdown_mmss (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] preset_min_tens,
  input  logic [3:0] preset_min_units,
  input  logic [2:0] preset_sec_tens,
  input  logic [3:0] preset_sec_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       running,
  output logic       valve_on,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] min_tens_reg, min_tens_next;
  logic [3:0] min_units_reg, min_units_next;
  logic [2:0] sec_tens_reg, sec_tens_next;
  logic [3:0] sec_units_reg, sec_units_next;

  // Clamped preset values
  logic [3:0] clamp_min_tens, clamp_min_units, clamp_sec_units;
  logic [2:0] clamp_sec_tens;
  logic       clamp_zero;

  // One-second decrement of the current count
  logic [3:0] dec_min_tens, dec_min_units, dec_sec_units;
  logic [2:0] dec_sec_tens;
  logic       borrow_su, borrow_st, borrow_mu;
  logic       dec_zero;

  always_comb begin
    clamp_min_tens  = (preset_min_tens  > 4'd9) ? 4'd9 : preset_min_tens;
    clamp_min_units = (preset_min_units > 4'd9) ? 4'd9 : preset_min_units;
    clamp_sec_tens  = (preset_sec_tens  > 3'd5) ? 3'd5 : preset_sec_tens;
    clamp_sec_units = (preset_sec_units > 4'd9) ? 4'd9 : preset_sec_units;
    clamp_zero = (clamp_min_tens == 4'd0) && (clamp_min_units == 4'd0) &&
                 (clamp_sec_tens == 3'd0) && (clamp_sec_units == 4'd0);
  end

  // Borrow ripples through the whole chain in one cycle.
  always_comb begin
    borrow_su     = (sec_units_reg == 4'd0);
    dec_sec_units = borrow_su ? 4'd9 : sec_units_reg - 4'd1;

    borrow_st     = borrow_su && (sec_tens_reg == 3'd0);
    dec_sec_tens  = !borrow_su ? sec_tens_reg :
                    (sec_tens_reg == 3'd0) ? 3'd5 : sec_tens_reg - 3'd1;

    borrow_mu     = borrow_st && (min_units_reg == 4'd0);
    dec_min_units = !borrow_st ? min_units_reg :
                    (min_units_reg == 4'd0) ? 4'd9 : min_units_reg - 4'd1;

    // min_tens cannot underflow: 00:00 leaves RUN before another tick.
    dec_min_tens  = borrow_mu ? min_tens_reg - 4'd1 : min_tens_reg;

    dec_zero = (dec_min_tens == 4'd0) && (dec_min_units == 4'd0) &&
               (dec_sec_tens == 3'd0) && (dec_sec_units == 4'd0);
  end

  always_comb begin
    state_next     = state_reg;
    min_tens_next  = min_tens_reg;
    min_units_next = min_units_reg;
    sec_tens_next  = sec_tens_reg;
    sec_units_next = sec_units_reg;
    case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          min_tens_next  = clamp_min_tens;
          min_units_next = clamp_min_units;
          sec_tens_next  = clamp_sec_tens;
          sec_units_next = clamp_sec_units;
          // A zero preset goes straight to DONE so the valve never opens.
          state_next     = clamp_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = PAUSE;  // coincident tick is dropped
        end else if (tick) begin
          min_tens_next  = dec_min_tens;
          min_units_next = dec_min_units;
          sec_tens_next  = dec_sec_tens;
          sec_units_next = dec_sec_units;
          if (dec_zero) state_next = DONE;
        end
      end
      PAUSE: begin
        if (stop) begin
          min_tens_next  = 4'd0;
          min_units_next = 4'd0;
          sec_tens_next  = 3'd0;
          sec_units_next = 4'd0;
          state_next     = IDLE;
        end else if (start) begin
          state_next = RUN;
        end
      end
      DONE: begin
        min_tens_next  = 4'd0;
        min_units_next = 4'd0;
        sec_tens_next  = 3'd0;
        sec_units_next = 4'd0;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      min_tens_reg  <= 4'd0;
      min_units_reg <= 4'd0;
      sec_tens_reg  <= 3'd0;
      sec_units_reg <= 4'd0;
    end else begin
      state_reg     <= state_next;
      min_tens_reg  <= min_tens_next;
      min_units_reg <= min_units_next;
      sec_tens_reg  <= sec_tens_next;
      sec_units_reg <= sec_units_next;
    end
  end

  assign min_tens  = min_tens_reg;
  assign min_units = min_units_reg;
  assign sec_tens  = sec_tens_reg;
  assign sec_units = sec_units_reg;
  assign running   = (state_reg == RUN);
  assign valve_on  = (state_reg == RUN);
  assign done      = (state_reg == DONE);

endmodule

// File: doc/countdown_mmss.md
# countdown_mmss

Four-digit BCD minutes:seconds countdown that sets the irrigation run time for one valve. It sits directly downstream of the 1 Hz tick generator and implements the seconds-tens digit as a 5→0 wrapping counter, cascaded with 9→0 digits. A start/stop control FSM sits around the digit chain. Outputs drive the valve enable and the display digits.

## Interface
Parameters:
- none; digit widths are fixed by BCD mm:ss format.

Ports:
- clock  in  1  system clock; every flop updates on the rising edge
- reset  in  1  synchronous, active-high reset
- tick  in  1  1 Hz enable pulse, one clock wide; decrements the count by one second
- start  in  1  level sampled each cycle; IDLE: load preset and run; PAUSE: resume
- stop  in  1  level sampled each cycle; RUN: pause; PAUSE: abort
- preset_min_tens  in  4  BCD minutes tens
- preset_min_units  in  4  BCD minutes units
- preset_sec_tens  in  3  seconds tens, 0–5
- preset_sec_units  in  4  BCD seconds units
- min_tens  out  4  current minutes tens
- min_units  out  4  current minutes units
- sec_tens  out  3  current seconds tens
- sec_units  out  4  current seconds units
- running  out  1  high in RUN
- valve_on  out  1  high in RUN and PAUSE_HOLD, which is the same as RUN only; low in PAUSE
- done  out  1  one-cycle pulse when the count expires

## Operation
- **States:** IDLE, RUN, PAUSE, DONE. Registered state; all outputs are decoded from registers.
- **Reset:** synchronous reset forces the following.
  - State = IDLE.
  - All digits = 0.
  - running = 0, valve_on = 0, done = 0.
  - Reset overrides every other input in the same cycle.
- **IDLE**
  - start=1 and stop=0: load all four preset digits, then go to RUN.
  - Preset digits are clamped before loading:
    - units and minutes-tens values above 9 load as 9;
    - sec_tens values above 5 load as 5.
  - If the clamped preset is 00:00: do not enter RUN. Go to DONE instead, so done pulses and the valve never opens.
  - tick is ignored in IDLE.
- **RUN**
  - tick=1 and stop=0: decrement by one second with borrow.
  - sec_units: 0→9 and borrow into sec_tens; otherwise subtract 1.
  - sec_tens: on borrow, 0→5 and borrow into min_units; otherwise subtract 1.
  - min_units: on borrow, 0→9 and borrow into min_tens; otherwise subtract 1.
  - min_tens: on borrow, subtract 1. It never underflows, because 00:00 exits RUN first.
  - If the decremented value is 00:00: the next state is DONE.
  - stop=1: go to PAUSE and hold the digits. stop has priority over a coincident tick, which is dropped.
  - start is ignored in RUN.
- **PAUSE**
  - Digits are frozen and tick is ignored.
  - start=1 and stop=0: return to RUN with no reload.
  - stop=1: abort. Clear all digits to 0 and go to IDLE. done is not pulsed.
- **DONE**
  - Lasts exactly one cycle, with done=1 and digits=00:00.
  - Then go to IDLE unconditionally. start and stop are ignored during that cycle.
- **Simultaneous start and stop:** stop always wins.
- **Mid-operation reset:** identical to reset at power-up. No done pulse; valve_on drops in the same edge.

## Timing
- start sampled high in IDLE at edge N:
  - state = RUN after edge N;
  - digits = clamped preset after edge N;
  - running = valve_on = 1 after edge N.
- tick high at edge T while in RUN: the new digit value is visible after edge T (1-cycle latency).
- Final tick at edge T that yields 00:00:
  - after T: state DONE, done=1, running=0, valve_on=0;
  - after T+1: IDLE, done=0.
- Zero preset with start at edge N: DONE after N, IDLE after N+1.
- stop at edge S in RUN: valve_on=0 after S.
- start at edge R in PAUSE: valve_on=1 after R.
- Borrow ripples through all digits within one cycle (combinational next-state). Example: 10:00 → 09:59 in a single tick.

## Test plan
- Reset behaviour: reset held 2 cycles during RUN at 03:27 → all digits 0, IDLE, valve_on=0 on the next edge, no done pulse.
- Short run: preset 00:03, start, 3 ticks → 00:02, 00:01, then 00:00 with a done pulse on the cycle after the third tick. valve_on is high for exactly the RUN span.
- Full borrow chain: preset 10:00, start, 1 tick → 09:59. Then 59 more ticks → 09:00. Then 1 more tick → 08:59.
- Pause, resume and abort:
  - preset 01:00, 5 ticks → 00:55;
  - stop → PAUSE with ticks ignored, digits stay 00:55;
  - start → RUN resumes at 00:55;
  - stop, then stop again → IDLE with 00:00 and no done pulse.
- Priority and clamping:
  - stop coincident with tick in RUN → no decrement, PAUSE.
  - start+stop together in IDLE → stays IDLE.
  - preset min_tens=12, sec_tens=7, sec_units=11 loads as 9x:59 (x = preset min_units).
- Zero preset: 00:00 with start → done pulse after one cycle, valve_on never asserted, back to IDLE.
